// File: rtl/intr_priority_ctrl_pkg.sv
// Shared types and constants for the interrupt priority controller.
// Holds the controller state encoding and vector limits.
package intc_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    SVC     = 3'd2,
    NMI_REQ = 3'd3,
    NMI_SVC = 3'd4
  } state_e;

  localparam logic [3:0] NMI_VECTOR = 4'hF;
  localparam int         MAX_IRQ    = 15;

endpackage

// File: rtl/intr_priority_ctrl_if.sv
// Request-source / CPU bundle of the interrupt priority controller.
// The slave modport is the controller; the master modport is its environment.
interface intr_priority_ctrl_if #(parameter int NUM_IRQ = 8);

  logic               nmi_req;
  logic [NUM_IRQ-1:0] irq_req;
  logic [NUM_IRQ-1:0] irq_mask;
  logic               global_ie;
  logic               cpu_int_ack;
  logic               cpu_eoi;
  logic               cpu_int_req;
  logic [3:0]         int_vector;
  logic [NUM_IRQ-1:0] irq_pending;
  logic               in_service;

  modport master (
    output nmi_req, irq_req, irq_mask, global_ie, cpu_int_ack, cpu_eoi,
    input  cpu_int_req, int_vector, irq_pending, in_service
  );

  modport slave (
    input  nmi_req, irq_req, irq_mask, global_ie, cpu_int_ack, cpu_eoi,
    output cpu_int_req, int_vector, irq_pending, in_service
  );

endinterface

// File: rtl/intr_priority_ctrl_encoder.sv
// Fixed-priority encoder: the lowest set request index wins.
// valid is high whenever any request bit is set.
module irq_priority_encoder #(
  parameter int N     = 8,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    idx = '0;
    // Scan downwards so the lowest index is the last assignment to stick.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/intr_priority_ctrl.sv
// Interrupt priority controller: NMI plus NUM_IRQ maskable sources, fixed priority,
// one CPU request line with a registered vector and single-level NMI nesting over SVC.
module intr_priority_ctrl
  import intc_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input logic                 clk,
  input logic                 rst,
  intr_priority_ctrl_if.slave bus
);

  state_e             state, state_nx;
  logic               nmi_pend, nmi_pend_nx;
  logic [NUM_IRQ-1:0] irq_pend, irq_pend_nx;
  logic [NUM_IRQ-1:0] eligible, ack_clr;
  logic               nested, nested_nx;
  logic [3:0]         saved_vec, saved_vec_nx;
  logic [3:0]         vec, vec_nx;
  logic               int_req, int_req_nx;
  logic               clr_irq, clr_nmi;
  logic               win_valid;
  logic [3:0]         win_idx;

  assign eligible = irq_pend & ~bus.irq_mask & {NUM_IRQ{bus.global_ie}};

  irq_priority_encoder #(
    .N     (NUM_IRQ),
    .IDX_W (4)
  ) u_enc (
    .req   (eligible),
    .valid (win_valid),
    .idx   (win_idx)
  );

  // The frozen vector identifies which pending latch the acknowledge retires.
  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      ack_clr[i] = clr_irq && (vec == 4'(i));
    end
  end

  // A new pulse wins over a same-cycle clear so no request is lost.
  assign irq_pend_nx = (irq_pend & ~ack_clr) | bus.irq_req;
  assign nmi_pend_nx = (nmi_pend & ~clr_nmi) | bus.nmi_req;

  always_comb begin
    state_nx     = state;
    int_req_nx   = int_req;
    vec_nx       = vec;
    nested_nx    = nested;
    saved_vec_nx = saved_vec;
    clr_irq      = 1'b0;
    clr_nmi      = 1'b0;
    unique case (state)
      IDLE: begin
        if (nmi_pend) begin
          state_nx   = NMI_REQ;
          int_req_nx = 1'b1;
          vec_nx     = NMI_VECTOR;
        end else if (win_valid) begin
          state_nx   = REQ;
          int_req_nx = 1'b1;
          vec_nx     = win_idx;
        end
      end
      REQ: begin
        if (bus.cpu_int_ack) begin
          clr_irq    = 1'b1;
          int_req_nx = 1'b0;
          state_nx   = SVC;
        end
      end
      SVC: begin
        // An EOI retires the handler first; a waiting NMI is then taken from IDLE.
        if (bus.cpu_eoi) begin
          state_nx = IDLE;
        end else if (nmi_pend) begin
          state_nx     = NMI_REQ;
          nested_nx    = 1'b1;
          saved_vec_nx = vec;
          int_req_nx   = 1'b1;
          vec_nx       = NMI_VECTOR;
        end
      end
      NMI_REQ: begin
        if (bus.cpu_int_ack) begin
          clr_nmi    = 1'b1;
          int_req_nx = 1'b0;
          state_nx   = NMI_SVC;
        end
      end
      NMI_SVC: begin
        if (bus.cpu_eoi) begin
          nested_nx = 1'b0;
          if (nested) begin
            state_nx = SVC;
            vec_nx   = saved_vec;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      nmi_pend  <= 1'b0;
      irq_pend  <= '0;
      nested    <= 1'b0;
      saved_vec <= 4'h0;
      vec       <= 4'h0;
      int_req   <= 1'b0;
    end else begin
      state     <= state_nx;
      nmi_pend  <= nmi_pend_nx;
      irq_pend  <= irq_pend_nx;
      nested    <= nested_nx;
      saved_vec <= saved_vec_nx;
      vec       <= vec_nx;
      int_req   <= int_req_nx;
    end
  end

  assign bus.cpu_int_req = int_req;
  assign bus.int_vector  = vec;
  assign bus.irq_pending = irq_pend;
  assign bus.in_service  = (state == SVC) || (state == NMI_SVC);

endmodule

// File: doc/intr_priority_ctrl.md
INTR_PRIORITY_CTRL -- requirements
Module: intr_priority_ctrl

Interface
REQ-001 Parameter NUM_IRQ, default 8, SHALL set the number of maskable request inputs (legal range 1..15).
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 nmi_req  input  1  SHALL be a one-cycle NMI request pulse from the NMI edge-detect unit.
REQ-005 irq_req  input  NUM_IRQ  SHALL carry one-cycle maskable request pulses, one bit per source.
REQ-006 irq_mask  input  NUM_IRQ  SHALL block arbitration of pending source i when bit i is 1.
REQ-007 global_ie  input  1  SHALL enable arbitration of maskable sources when 1; it has no effect on NMI.
REQ-008 cpu_int_ack  input  1  SHALL be the CPU acknowledge of the presented request.
REQ-009 cpu_eoi  input  1  SHALL be a one-cycle end-of-interrupt pulse from the CPU.
REQ-010 cpu_int_req  output  1  SHALL be the registered interrupt request to the CPU.
REQ-011 int_vector  output  4  SHALL carry the registered vector: 4'hF for NMI, i for irq_req[i].
REQ-012 irq_pending  output  NUM_IRQ  SHALL expose the maskable pending latches.
REQ-013 in_service  output  1  SHALL be 1 while any interrupt is being serviced (SVC or NMI_SVC).

Function
REQ-014 A pulse on nmi_req or irq_req[i] SHALL set the corresponding pending latch; the latch holds until the request is acknowledged, whatever the mask state.
REQ-015 If a pending bit is cleared by acknowledge in the same cycle as a new pulse for that source, the bit SHALL remain set.
REQ-016 Eligible sources: NMI when pending; irq i when pending, irq_mask[i]=0 and global_ie=1.
REQ-017 Priority SHALL be fixed: NMI highest, then irq 0, then irq 1, and so on, with irq NUM_IRQ-1 lowest.
REQ-018 The FSM SHALL have the states IDLE, REQ, SVC, NMI_REQ and NMI_SVC.
REQ-019 IDLE: if NMI is pending, the next state SHALL be NMI_REQ; otherwise, if any irq is eligible, the next state SHALL be REQ; either transition sets cpu_int_req=1 and int_vector=winner on that same edge (1-cycle latency from an eligible pending bit).
REQ-020 REQ/NMI_REQ: int_vector SHALL be frozen; mask or global_ie changes SHALL NOT withdraw the request.
REQ-021 REQ with cpu_int_ack=1: the FSM SHALL clear the winner's pending bit, drop cpu_int_req and enter SVC; the same applies in NMI_REQ, entering NMI_SVC.
REQ-022 SVC: a maskable request SHALL NOT preempt; a pending NMI SHALL move the FSM to NMI_REQ, set the nested flag and present vector 4'hF.
REQ-023 NMI_SVC with cpu_eoi: the FSM SHALL go to SVC, restoring int_vector to the saved irq vector, if the nested flag is set; otherwise it goes to IDLE; the nested flag is cleared.
REQ-024 SVC with cpu_eoi SHALL return the FSM to IDLE; arbitration resumes from IDLE on the next cycle.
REQ-025 The FSM SHALL ignore cpu_int_ack outside REQ/NMI_REQ and cpu_eoi outside SVC/NMI_SVC.
REQ-026 NMI pulses during NMI_REQ/NMI_SVC SHALL re-set the NMI pending latch for service after EOI.

Reset
REQ-027 Assertion of rst SHALL immediately force: state=IDLE; all pending latches, nested flag and saved vector=0; cpu_int_req=0; int_vector=4'h0; in_service=0.
REQ-028 Request pulses that coincide with asserted rst SHALL be discarded; reset mid-service SHALL abandon the service without producing an EOI.

Structure
REQ-029 Package intc_pkg SHALL hold the state enum, NMI_VECTOR=4'hF and MAX_IRQ=15.
REQ-030 The design SHALL contain one sub-module, irq_priority_encoder (parameterised lowest-index-wins encoder with valid output), instantiated for the maskable set.

Verification
REQ-031 Pulse irq_req[3] with mask=0 and global_ie=1 -> one cycle later cpu_int_req=1, int_vector=3; ack -> irq_pending[3]=0, in_service=1.
REQ-032 Pulse irq 2 and irq 5 in the same cycle -> vector 2 served first; after EOI, vector 5 is requested.
REQ-033 Set irq_mask[1]=1 and pulse irq 1 -> no request, irq_pending[1]=1; clear the mask -> request with vector 1.
REQ-034 During SVC of irq 4, pulse nmi_req -> vector F requested; ack, then EOI -> back in SVC with vector 4; second EOI -> IDLE.
REQ-035 global_ie=0 with an NMI pulse -> vector F requested; acknowledge coincident with a new irq 0 pulse -> irq_pending[0]=1 after the acknowledge.
REQ-036 Assert rst in REQ -> outputs are 0 immediately, and no request follows after release.
